// File: rtl/mem_pkg.sv
// Shared types and sizing for the load/store unit and its store buffer.
// ADDR_BITS / DATA_BITS track the data RAM; override the macros to resize both together.
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

package mem_pkg;

    localparam int unsigned ADDR_BITS   = `ADDR_BITS;
    localparam int unsigned DATA_BITS   = `DATA_BITS;
    localparam int unsigned SB_DEPTH    = 4;
    localparam int unsigned SB_PTR_BITS = $clog2(SB_DEPTH);
    localparam int unsigned SB_CNT_BITS = $clog2(SB_DEPTH + 1);

    typedef logic [SB_PTR_BITS-1:0] sb_ptr_t;
    typedef logic [SB_CNT_BITS-1:0] sb_cnt_t;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_forward_match.sv
// Combinational store-to-load forwarding search.
// Among valid entries matching lookup_addr, the one closest to the tail wins.
module sb_forward_match
    import mem_pkg::*;
(
    input  sb_entry_t [SB_DEPTH-1:0] entries,
    input  logic [SB_DEPTH-1:0]      valid,
    input  sb_ptr_t                  tail,
    input  logic [ADDR_BITS-1:0]     lookup_addr,
    output logic                     hit,
    output logic [DATA_BITS-1:0]     data
);

    always_comb begin
        sb_ptr_t idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        // Walk oldest to youngest so the last match written is the youngest.
        for (int unsigned age = SB_DEPTH; age >= 1; age--) begin
            idx = tail - sb_ptr_t'(age);
            if (valid[idx] && entries[idx].addr == lookup_addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage front end: in-order store buffer draining into the data RAM,
// with single-cycle load response and forwarding from pending stores.
module load_store_unit
    import mem_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    input  logic                 drain_en,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 sb_empty,
    output logic [ADDR_BITS-1:0] ram_addr_write,
    output logic [DATA_BITS-1:0] ram_data_write,
    output logic [ADDR_BITS-1:0] ram_addr_read,
    input  logic [DATA_BITS-1:0] ram_data_read
);

    sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
    sb_ptr_t                  head_q, head_d;
    sb_ptr_t                  tail_q, tail_d;
    sb_cnt_t                  count_q, count_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [SB_DEPTH-1:0]      sb_valid;
    logic                     fire, push, pop, load_fire;
    logic                     fwd_hit;
    logic [DATA_BITS-1:0]     fwd_data;
    sb_entry_t                head_entry;

    assign req_ready  = (count_q != sb_cnt_t'(SB_DEPTH));
    assign sb_empty   = (count_q == '0);
    assign fire       = req_valid & req_ready;
    assign push       = fire & req_write;
    assign load_fire  = fire & ~req_write;
    assign pop        = drain_en & ~sb_empty;
    assign head_entry = sb_q[head_q];

    // When nothing retires, rewrite the word being read so the RAM write is a no-op.
    assign ram_addr_read  = req_addr;
    assign ram_addr_write = pop ? head_entry.addr : req_addr;
    assign ram_data_write = pop ? head_entry.data : ram_data_read;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        sb_ptr_t offs;
        offs = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            offs        = sb_ptr_t'(i) - head_q;
            sb_valid[i] = sb_cnt_t'(offs) < count_q;
        end
    end

    sb_forward_match u_fwd (
        .entries     (sb_q),
        .valid       (sb_valid),
        .tail        (tail_q),
        .lookup_addr (req_addr),
        .hit         (fwd_hit),
        .data        (fwd_data)
    );

    always_comb begin
        sb_d        = sb_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rsp_valid_d = load_fire;
        rsp_rdata_d = rsp_rdata_q;

        if (push) begin
            sb_d[tail_q].addr = req_addr;
            sb_d[tail_q].data = req_wdata;
            tail_d            = tail_q + sb_ptr_t'(1);
        end
        if (pop) begin
            head_d = head_q + sb_ptr_t'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + sb_cnt_t'(1);
            2'b01:   count_d = count_q - sb_cnt_t'(1);
            default: count_d = count_q;
        endcase
        if (load_fire) begin
            rsp_rdata_d = fwd_hit ? fwd_data : ram_data_read;
        end
    end

    always_ff @(posedge clock) begin
        sb_q <= sb_d;
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
